// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and handshake pulses.
// Occupancy flags are decoded combinationally from the entry count.
module sync_fifo #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  almostfull,
    output logic                  empty,
    output logic                  almostempty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_go, rd_go;

    assign full        = (count_q == DEPTH_C);
    assign almostfull  = (count_q == DEPTH_C - CW'(1));
    assign empty       = (count_q == '0);
    assign almostempty = (count_q == CW'(1));

    assign data_out  = data_out_q;
    assign wr_ack    = wr_ack_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // A read never frees a slot for a same-cycle write, and a write
    // never bypasses to a same-cycle read.
    assign wr_go = wr_en && !full;
    assign rd_go = rd_en && !empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        wr_ack_d    = wr_go;
        overflow_d  = wr_en && !wr_go;
        underflow_d = rd_en && !rd_go;
        if (wr_go) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_go) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            data_out_d = mem_q[rd_ptr_q];
        end
        unique case ({wr_go, rd_go})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (wr_go) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised and directed bench for sync_fifo against a queue model.
// Outputs are compared on the falling edge after each rising edge.
module tb_sync_fifo;

    localparam int W = 16;
    localparam int D = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] data_in;
    logic         wr_en;
    logic         rd_en;
    logic [W-1:0] data_out;
    logic         wr_ack;
    logic         overflow;
    logic         underflow;
    logic         full;
    logic         almostfull;
    logic         empty;
    logic         almostempty;

    int total;
    int bad;

    logic [W-1:0] q[$];
    logic [W-1:0] m_dout;
    logic         m_ack;
    logic         m_ovf;
    logic         m_udf;

    sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .wr_ack      (wr_ack),
        .overflow    (overflow),
        .underflow   (underflow),
        .full        (full),
        .almostfull  (almostfull),
        .empty       (empty),
        .almostempty (almostempty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check({tag, ".dout"}, 32'(data_out), 32'(m_dout));
        check({tag, ".ack"}, 32'(wr_ack), 32'(m_ack));
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".udf"}, 32'(underflow), 32'(m_udf));
        check({tag, ".full"}, 32'(full), 32'(n == D));
        check({tag, ".afull"}, 32'(almostfull), 32'(n == D - 1));
        check({tag, ".empty"}, 32'(empty), 32'(n == 0));
        check({tag, ".aempty"}, 32'(almostempty), 32'(n == 1));
        check({tag, ".onehot"},
              32'(32'(full) + 32'(almostfull) + 32'(empty)
                  + 32'(almostempty) <= 1), 32'(1));
        check({tag, ".ackovf"}, 32'(wr_ack && overflow), 32'(0));
    endtask

    // One clock: drive, let the edge happen, update the model, compare.
    task automatic cycle(input string tag, input logic wr, input logic rd,
                         input logic [W-1:0] din);
        logic was_full;
        logic was_empty;
        logic wa;
        logic ra;
        wr_en   = wr;
        rd_en   = rd;
        data_in = din;
        @(posedge clk);
        was_full  = (q.size() == D);
        was_empty = (q.size() == 0);
        wa = wr && !was_full;
        ra = rd && !was_empty;
        if (ra) m_dout = q.pop_front();
        if (wa) q.push_back(din);
        m_ack = wa;
        m_ovf = wr && !wa;
        m_udf = rd && !ra;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_all(tag);
    endtask

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_ack  = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    initial begin
        logic [W-1:0] k;
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("rst0");
        rst = 1'b0;

        // Reset mid-stream, checked before any clock edge.
        cycle("pre1", 1'b1, 1'b0, 16'h1111);
        cycle("pre2", 1'b1, 1'b0, 16'h2222);
        cycle("pre3", 1'b1, 1'b1, 16'h3333);
        cycle("pre4", 1'b1, 1'b0, 16'h4444);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("arst");
        @(negedge clk);
        rst = 1'b0;
        cycle("aaw", 1'b1, 1'b0, 16'hAAAA);
        cycle("aar", 1'b0, 1'b1, 16'h0);
        check("aa_data", 32'(data_out), 32'h0000AAAA);

        // Fill, overflow, drain, underflow.
        for (int i = 1; i <= D; i++) begin
            cycle("fill", 1'b1, 1'b0, W'(i));
        end
        check("full8", 32'(full), 32'(1));
        cycle("ovf9", 1'b1, 1'b0, 16'h0009);
        check("ovf9_flag", 32'(overflow), 32'(1));
        for (int i = 1; i <= D; i++) begin
            cycle("drain", 1'b0, 1'b1, 16'h0);
            check("drain_order", 32'(data_out), 32'(i));
        end
        cycle("udf9", 1'b0, 1'b1, 16'h0);
        check("udf9_hold", 32'(data_out), 32'h00000008);

        // Simultaneous requests at full, then at empty.
        for (int i = 0; i < D; i++) begin
            cycle("refill", 1'b1, 1'b0, W'(16'h0100 + i));
        end
        cycle("both_full", 1'b1, 1'b1, 16'hBEEF);
        check("both_full_afull", 32'(almostfull), 32'(1));
        check("both_full_dout", 32'(data_out), 32'h00000100);
        for (int i = 0; i < D - 1; i++) begin
            cycle("redrain", 1'b0, 1'b1, 16'h0);
        end
        cycle("both_empty", 1'b1, 1'b1, 16'h1234);
        check("both_empty_udf", 32'(underflow), 32'(1));
        cycle("both_empty_rd", 1'b0, 1'b1, 16'h0);
        check("both_empty_data", 32'(data_out), 32'h00001234);

        // Steady occupancy 4 across pointer wrap.
        k = 16'h0500;
        for (int i = 0; i < 4; i++) begin
            cycle("wrap_fill", 1'b1, 1'b0, k);
            k++;
        end
        for (int i = 0; i < 20; i++) begin
            cycle("wrap", 1'b1, 1'b1, k);
            check("wrap_order", 32'(data_out), 32'(k - 16'd4));
            k++;
        end

        // Random traffic with shifting read/write bias.
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (i / 100) % 3;
            cycle("rand",
                  ($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5))),
                  ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5))),
                  W'($urandom));
            if (i == 300) begin
                #2 rst = 1'b1;
                #1;
                model_reset();
                check_all("rand_arst");
                @(negedge clk);
                rst = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

- Single-clock synchronous FIFO: the design under test that the FIFO interface monitor samples every negative clock edge.
- Buffers `FIFO_WIDTH`-bit words, up to `FIFO_DEPTH` entries.
- Provides registered write-acknowledge, overflow and underflow pulses, plus combinational full, almostfull, empty and almostempty flags.
- Port names match the FIFO interface signals the monitor records, so it binds to that interface unchanged.

## Interface
- `FIFO_WIDTH`, 16: data word width in bits.
- `FIFO_DEPTH`, 8: number of entries. Must be a power of 2 and ≥ 4.
- `clk`  in  1: the single clock. All state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `data_in`  in  FIFO_WIDTH: write data.
- `wr_en`  in  1: write request.
- `rd_en`  in  1: read request.
- `data_out`  out  FIFO_WIDTH: registered read data.
- `wr_ack`  out  1: registered pulse; the previous-cycle write was accepted.
- `overflow`  out  1: registered pulse; the previous-cycle write was rejected.
- `underflow`  out  1: registered pulse; the previous-cycle read was rejected.
- `full`, `almostfull`, `empty`, `almostempty`  out  1 each: occupancy flags, combinational from `count`.

## Operation
- **Internal state**
  - Storage `mem[FIFO_DEPTH]`.
  - `wr_ptr`, `rd_ptr`: clog2(FIFO_DEPTH) bits each; wrap naturally from DEPTH-1 to 0.
  - `count`: clog2(FIFO_DEPTH)+1 bits.
- **Reset (`rst`=1), immediate and asynchronous**
  - Pointers, `count`, `data_out`, `wr_ack`, `overflow` and `underflow` go to 0.
  - Resulting flags: `empty`=1, all other flags 0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored data; the first write after reset lands at entry 0.
- **Write accepted**: `wr_en`=1 and (`full`=0, or `rd_en`=1 with the FIFO not full).
  - `mem[wr_ptr]`←`data_in`, `wr_ptr`++.
  - `wr_ack`←1, `overflow`←0.
- **Write rejected**: `wr_en`=1 while `full`=1.
  - Nothing is stored; `wr_ack`←0, `overflow`←1.
  - `rd_en` does not free a slot for a same-cycle write.
- **No write** (`wr_en`=0): `wr_ack`←0, `overflow`←0.
- **Read accepted**: `rd_en`=1 and `empty`=0.
  - `data_out`←`mem[rd_ptr]`, `rd_ptr`++, `underflow`←0.
- **Read rejected**: `rd_en`=1 while `empty`=1.
  - `underflow`←1; `data_out` holds its value.
  - A same-cycle write does not bypass to the read.
- **No read** (`rd_en`=0): `underflow`←0, `data_out` holds.
- **Count update**: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- **Simultaneous `wr_en` and `rd_en`**
  - Full: read accepted, write rejected; `count` goes to DEPTH-1.
  - Empty: write accepted, read rejected; `count` goes to 1.
  - Otherwise: both accepted; `count` unchanged.
- **Flags**
  - `full` = (`count`==DEPTH)
  - `almostfull` = (`count`==DEPTH-1)
  - `empty` = (`count`==0)
  - `almostempty` = (`count`==1)
- **Invariants**
  - At most one of `empty`/`almostempty`/`almostfull`/`full` is high at a time.
  - `wr_ack` and `overflow` are never both high.

## Timing
- Write-to-read latency: a word written at edge N can be read at edge N+1 at the earliest; it appears on `data_out` after edge N+1.
- `wr_ack`, `overflow` and `underflow` are valid for exactly one cycle, after the edge that processed the request.
- Flags update in the same cycle as `count`, after the edge.
- All inputs are sampled on the rising edge. The monitor samples outputs at the following falling edge.
- Reset assertion takes effect without a clock. Deassertion is assumed synchronous to `clk` by the environment.

## Test plan
- **Reset:** assert `rst` mid-stream with 3 entries stored → immediately `empty`=1, `wr_ack`=`overflow`=`underflow`=0, `data_out`=0. Next write of 0xAAAA, then read → `data_out`=0xAAAA.
- **Fill to full:** write 0x0001..0x0008 → `wr_ack`=1 on each; `almostfull` after the 7th, `full` after the 8th. A 9th write of 0x0009 → `overflow`=1, `wr_ack`=0, `count` stays 8.
- **Drain in order:** 8 reads → `data_out` = 0x0001..0x0008 in order; `almostempty` after the 7th, `empty` after the 8th. A 9th read → `underflow`=1, `data_out` stays 0x0008.
- **Both requests while full:** `wr_en`=`rd_en`=1 → `data_out`=oldest entry, `overflow`=1, `wr_ack`=0, `almostfull`=1.
- **Both requests while empty:** `wr_en`=`rd_en`=1 with 0x1234 → `wr_ack`=1, `underflow`=1, `almostempty`=1. The next read returns 0x1234.
- **Wrap-around:** 20 cycles of simultaneous write/read at steady occupancy 4 with incrementing data → read data strictly follows write order across pointer wrap; `count` stays 4 and no flag other than `wr_ack` pulses.
